// File: rtl/kyber_encrypt_core.sv
// kyber_encrypt_core
//   Sequential Kyber-style encryption datapath over Z_Q[x]/(x^N+1):
//     u[i] = sum_j A[j][i]*r[j] + e1[i]
//     v    = sum_j t[j]*r[j] + e2 + QHALF*message
//   One coefficient multiply-accumulate per cycle. u takes K*K*N*N cycles and v takes K*N*N
//   cycles. out_valid_o rises (K+1)*K*N*N edges after the accepting edge.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i / busy_o     request (taken only when idle) / operation in flight
//   message_i            plaintext bits; bit c drives coefficient c of v
//   a_mat_i              A[j][i] coefficient c at bit ((j*K+i)*N+c)*W
//   t_vec_i, r_vec_i,
//   e1_vec_i             poly i coefficient c at bit (i*N+c)*W
//   e2_poly_i            coefficient c at bit c*W
//   out_valid_o / out_ready_i  ciphertext handshake
//   u_out_o, v_out_o     ciphertext, packed the same way as the inputs
//
// Configuration
//   KYBER_ENC_CENTERED_EN  if defined, output coefficients are mapped to the centred range
//                          [-(Q-1)/2, (Q-1)/2] and sign-extended. Otherwise they are canonical
//                          values in [0, Q-1].
//
// Q*Q must fit in W bits so that the raw product does not wrap.
module kyber_encrypt_core #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 2,
    parameter int unsigned Q = 17,
    parameter int unsigned W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               busy_o,
    input  logic [N-1:0]       message_i,
    input  logic [K*K*N*W-1:0] a_mat_i,
    input  logic [K*N*W-1:0]   t_vec_i,
    input  logic [K*N*W-1:0]   r_vec_i,
    input  logic [K*N*W-1:0]   e1_vec_i,
    input  logic [N*W-1:0]     e2_poly_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [K*N*W-1:0]   u_out_o,
    output logic [N*W-1:0]     v_out_o
);

    localparam int unsigned NW  = $clog2(N);
    localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned AIW = $clog2(K * K * N);
    localparam int unsigned VIW = $clog2(K * N);
    localparam logic [W-1:0]  QW    = W'(Q);
    localparam logic [W-1:0]  QHALF = W'((Q + 1) / 2);
    localparam logic [NW-1:0] NMAX  = NW'(N - 1);
    localparam logic [KW-1:0] KMAX  = KW'(K - 1);

    typedef enum logic [1:0] {StIdle, StComputeU, StComputeV, StDone} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d, m_q, m_d;   // r coefficient, A/t coefficient
    logic [KW-1:0]   j_q, j_d, i_q, i_d;   // summation index, output polynomial
    logic            accept;
    logic            last_n, last_m, last_j, last_i;

    logic [W-1:0]    a_q  [K*K*N];
    logic [W-1:0]    t_q  [K*N];
    logic [W-1:0]    r_q  [K*N];
    logic [W-1:0]    u_q  [K*N];
    logic [W-1:0]    v_q  [N];

    logic [NW:0]     sum_idx;
    logic            wrap;
    logic [NW-1:0]   k_idx;
    logic [AIW-1:0]  a_idx;
    logic [VIW-1:0]  r_idx, t_idx, u_idx;
    logic            is_u;
    logic [W-1:0]    op_a, cur, prod, mac;

    // Signed input word to canonical [0, Q-1].
    function automatic logic [W-1:0] reduce_in(input logic [W-1:0] x);
        logic signed [W-1:0] r;
        r = $signed(x) % $signed(QW);
        if (r < 0) r = r + $signed(QW);
        return r;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
        return (s >= QW) ? s - QW : s;
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? a - b : a + (QW - b);
    endfunction

    function automatic logic [W-1:0] out_map(input logic [W-1:0] x);
`ifdef KYBER_ENC_CENTERED_EN
        // Two's-complement subtraction gives the sign-extended negative value directly.
        return (x > W'((Q - 1) / 2)) ? x - QW : x;
`else
        return x;
`endif
    endfunction

    // MAC datapath: product of coefficients m and n lands on x^(m+n). Because N is a power of
    // two, the carry out of the index sum flags the negacyclic wrap, which negates the term.
    always_comb begin
        sum_idx = {1'b0, m_q} + {1'b0, n_q};
        wrap    = sum_idx[NW];
        k_idx   = sum_idx[NW-1:0];
        a_idx   = AIW'((int'(j_q) * K + int'(i_q)) * N + int'(m_q));
        r_idx   = VIW'(int'(j_q) * N + int'(n_q));
        t_idx   = VIW'(int'(j_q) * N + int'(m_q));
        u_idx   = VIW'(int'(i_q) * N + int'(k_idx));
        is_u    = (state_q == StComputeU);
        op_a    = is_u ? a_q[a_idx] : t_q[t_idx];
        cur     = is_u ? u_q[u_idx] : v_q[k_idx];
        prod    = (op_a * r_q[r_idx]) % QW;
        mac     = wrap ? mod_sub(cur, prod) : mod_add(cur, prod);
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        j_d     = j_q;
        i_d     = i_q;
        accept  = 1'b0;
        last_n  = (n_q == NMAX);
        last_m  = (m_q == NMAX);
        last_j  = (j_q == KMAX);
        last_i  = (i_q == KMAX);
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = StComputeU;
                    n_d     = '0;
                    m_d     = '0;
                    j_d     = '0;
                    i_d     = '0;
                end
            end
            StComputeU, StComputeV: begin
                n_d = n_q + 1'b1;
                if (last_n) begin
                    m_d = m_q + 1'b1;
                    if (last_m) begin
                        j_d = last_j ? '0 : j_q + 1'b1;
                        if (last_j) i_d = i_q + 1'b1;
                    end
                end
                // v has no outer polynomial loop, so i is ignored there.
                if (last_n && last_m && last_j && (state_q == StComputeV || last_i)) begin
                    state_d = (state_q == StComputeU) ? StComputeV : StDone;
                    n_d     = '0;
                    m_d     = '0;
                    j_d     = '0;
                    i_d     = '0;
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            m_q     <= '0;
            j_q     <= '0;
            i_q     <= '0;
            for (int x = 0; x < K * K * N; x++) a_q[x] <= '0;
            for (int x = 0; x < K * N; x++) begin
                t_q[x] <= '0;
                r_q[x] <= '0;
                u_q[x] <= '0;
            end
            for (int x = 0; x < N; x++) v_q[x] <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            j_q     <= j_d;
            i_q     <= i_d;
            if (accept) begin
                // Accumulators start from the noise terms, so no final add pass is needed.
                for (int x = 0; x < K * K * N; x++) a_q[x] <= reduce_in(a_mat_i[x*W +: W]);
                for (int x = 0; x < K * N; x++) begin
                    t_q[x] <= reduce_in(t_vec_i[x*W +: W]);
                    r_q[x] <= reduce_in(r_vec_i[x*W +: W]);
                    u_q[x] <= reduce_in(e1_vec_i[x*W +: W]);
                end
                for (int x = 0; x < N; x++) begin
                    v_q[x] <= mod_add(reduce_in(e2_poly_i[x*W +: W]),
                                      message_i[x] ? QHALF : '0);
                end
            end else if (state_q == StComputeU) begin
                u_q[u_idx] <= mac;
            end else if (state_q == StComputeV) begin
                v_q[k_idx] <= mac;
            end
        end
    end

    always_comb begin
        busy_o      = (state_q == StComputeU) || (state_q == StComputeV);
        out_valid_o = (state_q == StDone);
        u_out_o     = '0;
        v_out_o     = '0;
        for (int x = 0; x < K * N; x++) u_out_o[x*W +: W] = out_map(u_q[x]);
        for (int x = 0; x < N; x++) v_out_o[x*W +: W] = out_map(v_q[x]);
    end

endmodule

// File: tb/tb_kyber_encrypt_core.sv
module tb_kyber_encrypt_core;

    localparam int N   = 4;
    localparam int K   = 2;
    localparam int Q   = 17;
    localparam int W   = 32;
    localparam int LAT = (K + 1) * K * N * N;
    localparam int AMW = K * K * N * W;
    localparam int UW  = K * N * W;
    localparam int VW  = N * W;
    localparam int CW  = AMW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy;
    logic [N-1:0]   message = '0;
    logic [AMW-1:0] a_mat = '0;
    logic [UW-1:0]  t_vec = '0;
    logic [UW-1:0]  r_vec = '0;
    logic [UW-1:0]  e1_vec = '0;
    logic [VW-1:0]  e2_poly = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [UW-1:0]  u_out;
    logic [VW-1:0]  v_out;

    int n_checks = 0;
    int n_fail   = 0;

    kyber_encrypt_core #(.N(N), .K(K), .Q(Q), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .message_i  (message),
        .a_mat_i    (a_mat),
        .t_vec_i    (t_vec),
        .r_vec_i    (r_vec),
        .e1_vec_i   (e1_vec),
        .e2_poly_i  (e2_poly),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .u_out_o    (u_out),
        .v_out_o    (v_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integer polynomial arithmetic) ----------------
    function automatic longint red(input logic [W-1:0] x);
        longint v;
        v = longint'($signed(x)) % Q;
        if (v < 0) v += Q;
        return v;
    endfunction

    function automatic logic [W-1:0] enc(input longint x);
`ifdef KYBER_ENC_CENTERED_EN
        if (x > (Q - 1) / 2) return W'(x - Q);
`endif
        return W'(x);
    endfunction

    function automatic logic [UW-1:0] model_u(input logic [AMW-1:0] a, input logic [UW-1:0] r,
                                              input logic [UW-1:0] e1);
        longint acc [K][N];
        longint p, x;
        logic [UW-1:0] res;
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) acc[i][c] = red(e1[(i*N+c)*W +: W]);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                for (int m = 0; m < N; m++)
                    for (int n = 0; n < N; n++) begin
                        p = red(a[((j*K+i)*N+m)*W +: W]) * red(r[(j*N+n)*W +: W]);
                        if (m + n < N) acc[i][m+n] += p;
                        else acc[i][m+n-N] -= p;
                    end
        res = '0;
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) begin
                x = acc[i][c] % Q;
                if (x < 0) x += Q;
                res[(i*N+c)*W +: W] = W'(x);
            end
        return res;
    endfunction

    function automatic logic [VW-1:0] model_v(input logic [UW-1:0] t, input logic [UW-1:0] r,
                                              input logic [VW-1:0] e2, input logic [N-1:0] msg);
        longint acc [N];
        longint p, x;
        logic [VW-1:0] res;
        for (int c = 0; c < N; c++) acc[c] = red(e2[c*W +: W]) + (msg[c] ? (Q + 1) / 2 : 0);
        for (int j = 0; j < K; j++)
            for (int m = 0; m < N; m++)
                for (int n = 0; n < N; n++) begin
                    p = red(t[(j*N+m)*W +: W]) * red(r[(j*N+n)*W +: W]);
                    if (m + n < N) acc[m+n] += p;
                    else acc[m+n-N] -= p;
                end
        res = '0;
        for (int c = 0; c < N; c++) begin
            x = acc[c] % Q;
            if (x < 0) x += Q;
            res[c*W +: W] = W'(x);
        end
        return res;
    endfunction

    function automatic logic [UW-1:0] map_u(input logic [UW-1:0] x);
        logic [UW-1:0] res;
        for (int c = 0; c < K * N; c++) res[c*W +: W] = enc(longint'(x[c*W +: W]));
        return res;
    endfunction

    function automatic logic [VW-1:0] map_v(input logic [VW-1:0] x);
        logic [VW-1:0] res;
        for (int c = 0; c < N; c++) res[c*W +: W] = enc(longint'(x[c*W +: W]));
        return res;
    endfunction

    // Transaction-level timing model: idle -> busy for LAT edges -> done until handshake.
    typedef enum int {MIdle, MBusy, MDone} mstate_e;
    mstate_e       m_st = MIdle;
    int            m_edges = 0;
    logic [UW-1:0] exp_u = '0;
    logic [VW-1:0] exp_v = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st    <= MIdle;
            m_edges <= 0;
        end else begin
            case (m_st)
                MIdle: if (start) begin
                    m_st    <= MBusy;
                    m_edges <= 0;
                    exp_u   <= map_u(model_u(a_mat, r_vec, e1_vec));
                    exp_v   <= map_v(model_v(t_vec, r_vec, e2_poly, message));
                end
                MBusy: begin
                    if (m_edges + 1 == LAT) m_st <= MDone;
                    m_edges <= m_edges + 1;
                end
                default: if (out_ready) m_st <= MIdle;
            endcase
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset busy", CW'(busy), CW'(1'b0));
            chk("reset out_valid", CW'(out_valid), CW'(1'b0));
            chk("reset u_out", CW'(u_out), CW'(0));
            chk("reset v_out", CW'(v_out), CW'(0));
        end else begin
            chk("busy", CW'(busy), CW'(m_st == MBusy));
            chk("out_valid", CW'(out_valid), CW'(m_st == MDone));
            if (m_st == MDone) begin
                chk("u_out", CW'(u_out), CW'(exp_u));
                chk("v_out", CW'(v_out), CW'(exp_v));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] rand_coef();
        if ($urandom_range(0, 7) == 0) return W'($urandom);
        return W'(int'($urandom_range(0, 2000)) - 1000);
    endfunction

    task automatic randomize_inputs();
        message = N'($urandom);
        for (int x = 0; x < K * K * N; x++) a_mat[x*W +: W] = rand_coef();
        for (int x = 0; x < K * N; x++) begin
            t_vec[x*W +: W]  = rand_coef();
            r_vec[x*W +: W]  = rand_coef();
            e1_vec[x*W +: W] = rand_coef();
        end
        for (int x = 0; x < N; x++) e2_poly[x*W +: W] = rand_coef();
    endtask

    task automatic zero_inputs();
        message = '0;
        a_mat   = '0;
        t_vec   = '0;
        r_vec   = '0;
        e1_vec  = '0;
        e2_poly = '0;
    endtask

    // Called #2 after a rising edge with the DUT idle.
    task automatic do_txn(input int hold, input bit scramble, input bit hs_start, input bit lit_en,
                          input logic [UW-1:0] u_lit, input logic [VW-1:0] v_lit);
        int lat;
        bit got;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy after accept", CW'(busy), CW'(1'b1));
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < LAT + 20; c++) begin
            @(posedge clk); #2;
            lat++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            start = 1'($urandom_range(0, 1));
            if (scramble) randomize_inputs();
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid timeout: waited %0d cycles, required %0d", lat, LAT);
        end
        chk("latency", CW'(lat), CW'(LAT));
        if (lit_en) begin
            chk("u_out literal", CW'(u_out), CW'(u_lit));
            chk("v_out literal", CW'(v_out), CW'(v_lit));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            chk("out_valid held", CW'(out_valid), CW'(1'b1));
        end
        out_ready = 1'b1;
        start     = hs_start;
        @(posedge clk); #2;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("out_valid after handshake", CW'(out_valid), CW'(1'b0));
        chk("busy after handshake", CW'(busy), CW'(1'b0));
        @(posedge clk); #2;
        chk("handshake start ignored", CW'(busy), CW'(1'b0));
    endtask

    logic [AMW-1:0] la;
    logic [UW-1:0]  lr, lu, lz;
    logic [VW-1:0]  lv, le2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Hand-computed pins for the model itself.
        lz = '0;
        lv = '0;
        lv[0*W +: W] = 9;
        lv[2*W +: W] = 9;
        chk("model msg only", CW'(model_v(lz, lz, '0, 4'b0101)), CW'(lv));
        la = '0;
        la[1*W +: W] = 1;
        lr = '0;
        lr[3*W +: W] = 1;
        lu = '0;
        lu[0 +: W] = 16;
        chk("model x*x^3 wrap", CW'(model_u(la, lr, lz)), CW'(lu));
        la[0 +: W] = 1;
        lr[0 +: W] = 2;
        lr[3*W +: W] = 3;
        lu = '0;
        lu[0*W +: W] = 16;
        lu[1*W +: W] = 2;
        lu[3*W +: W] = 3;
        chk("model (1+x)(2+3x^3)", CW'(model_u(la, lr, lz)), CW'(lu));
        le2 = '0;
        le2[1*W +: W] = '1;
        lv[1*W +: W] = 16;
        chk("model e2 negative", CW'(model_v(lz, lz, le2, 4'b0101)), CW'(lv));

        // Message only.
        @(posedge clk); #2;
        zero_inputs();
        message = 4'b0101;
        lv = '0;
        lv[0*W +: W] = 9;
        lv[2*W +: W] = 9;
        do_txn(10, 1'b0, 1'b0, 1'b1, lz, map_v(lv));

        // Negacyclic wrap: A[0][0]=x, r[0]=x^3.
        zero_inputs();
        a_mat[1*W +: W] = 1;
        r_vec[3*W +: W] = 1;
        lu = '0;
        lu[0 +: W] = 16;
        do_txn(2, 1'b0, 1'b1, 1'b1, map_u(lu), '0);

        // Negative noise coefficient.
        zero_inputs();
        message = 4'b0101;
        e2_poly[1*W +: W] = '1;
        lv = '0;
        lv[0*W +: W] = 9;
        lv[1*W +: W] = 16;
        lv[2*W +: W] = 9;
        do_txn(0, 1'b0, 1'b0, 1'b1, lz, map_v(lv));

        // Randomised traffic; inputs also change while busy.
        for (int t = 0; t < 8; t++) begin
            randomize_inputs();
            do_txn(int'($urandom_range(0, 5)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, lz, '0);
        end

        // Abort mid-operation with reset.
        randomize_inputs();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", CW'(busy), CW'(1'b0));
        chk("abort out_valid", CW'(out_valid), CW'(1'b0));
        chk("abort u_out", CW'(u_out), CW'(0));
        chk("abort v_out", CW'(v_out), CW'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        zero_inputs();
        message = 4'b0101;
        lv = '0;
        lv[0*W +: W] = 9;
        lv[2*W +: W] = 9;
        do_txn(3, 1'b0, 1'b0, 1'b1, lz, map_v(lv));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
